mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
- Multicycle successor to the single-cycle MIPS main decoder.
- Sequences each instruction over several states through one shared memory port and one ALU, with a memory-ready handshake and a bounded wait timeout.
- Traps on illegal opcodes and counts retired instructions.
- Sits between the instruction register opcode field and the datapath muxes and enables of the multicycle core.

Parameters:
OPCODE_W, 6, opcode field width
ALUOP_W, 3, width of o_alu_op
TIMEOUT, 15, max cycles waiting on i_mem_ready before trap (1..255)
CNT_W, 32, width of retired-instruction counter

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_rst  in  1  synchronous active-high reset
i_opcode  in  OPCODE_W  opcode from instruction register
i_zero  in  1  ALU zero flag, used in BRANCH
i_mem_ready  in  1  memory completes current access this cycle
i_trap_clr  in  1  leave TRAP state
o_pc_write  out  1  unconditional PC load
o_pc_write_cond  out  1  PC load if branch condition true (BEQ: i_zero=1, BNE: i_zero=0), already qualified
o_iord  out  1  0=PC address, 1=ALUOut address
o_mem_read  out  1  memory read request
o_mem_write  out  1  memory write request
o_ir_write  out  1  load instruction register
o_reg_dst  out  1  1=rd, 0=rt
o_memto_reg  out  1  1=MDR, 0=ALUOut
o_reg_write  out  1  register file write enable
o_alu_src_a  out  1  0=PC, 1=rs
o_alu_src_b  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
o_alu_op  out  ALUOP_W  000 add, 001 sub, 010 funct-decode, 011 slt, 100 and, 101 or, 110 xor
o_pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
o_illegal  out  1  high while in TRAP
o_instr_done  out  1  one-cycle pulse on instruction retire
o_retired  out  CNT_W  retired-instruction count
o_state  out  4  current state encoding, for debug

Behaviour:
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, I_EXEC=8, I_WB=9, BRANCH=10, JUMP=11, TRAP=12.
- Outputs are Moore-decoded from the state; the only exceptions are the ready-gated strobes and o_pc_write_cond. Every output not listed for a state is 0.
- Reset: state=FETCH, wait counter=0, o_retired=0. While i_rst=1, all outputs are forced to 0 except o_state, which reads 0.
- FETCH: o_mem_read=1, iord=0, src_a=0, src_b=01, alu_op=add, pc_src=00. o_ir_write and o_pc_write assert only in the cycle i_mem_ready=1, then go to DECODE. Otherwise stay in FETCH.
- DECODE: src_a=0, src_b=11, alu_op=add (branch target into ALUOut). Next state by opcode:
  - 000000 -> R_EXEC
  - 100011, 101011 -> MEM_ADDR
  - 000100, 000101 -> BRANCH
  - 001000, 001010, 001100, 001101, 001110 -> I_EXEC
  - 000010 -> JUMP
  - any other -> TRAP
- Opcode is latched at DECODE into an internal register, so later i_opcode changes are ignored until the next DECODE.
- MEM_ADDR: src_a=1, src_b=10, add. Next state MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_read=1, iord=1. Advance to MEM_WB when ready.
- MEM_WB: reg_write=1, reg_dst=0, memto_reg=1. Retire.
- MEM_WR: mem_write=1, iord=1. Retire and go to FETCH when ready.
- R_EXEC: src_a=1, src_b=00, alu_op=funct. Next R_WB.
- R_WB: reg_write=1, reg_dst=1, memto_reg=0. Retire.
- I_EXEC: src_a=1, src_b=10, alu_op by opcode: ADDI add, SLTI slt, ANDI and, ORI or, XORI xor. Next I_WB.
- I_WB: reg_write=1, reg_dst=0, memto_reg=0. Retire.
- BRANCH: src_a=1, src_b=00, sub, pc_src=01. o_pc_write_cond = (BEQ & i_zero) | (BNE & ~i_zero). Retire.
- JUMP: pc_src=10, pc_write=1. Retire.
- Retire: o_instr_done=1 for that single cycle, o_retired increments (wraps modulo 2^CNT_W), next state FETCH.
- Wait counter: increments each cycle spent in FETCH/MEM_RD/MEM_WR with i_mem_ready=0. It clears on ready or on state change.
  - If it reaches TIMEOUT while ready is still 0, next state is TRAP and no strobe is issued.
  - Ready arriving in the same cycle the counter hits TIMEOUT completes the access normally (ready wins).
- TRAP: o_illegal=1, all write enables 0. Stays until i_trap_clr=1, then FETCH. Not a retire.
- i_rst has priority over every transition, including mid-access. On reset no write strobe is emitted that cycle.

Test Plan:
- Reset then ADD (000000) with ready=1 every cycle -> states 0,1,6,7,0; reg_write=1 and reg_dst=1 in R_WB; o_retired=1 after 4 cycles.
- LW (100011) with ready delayed 3 cycles in MEM_RD -> MEM_RD held 4 cycles with mem_read=1, iord=1; then MEM_WB with memto_reg=1; 5-cycle-plus-wait total.
- BEQ with i_zero=1 -> o_pc_write_cond=1 in BRANCH. BNE with i_zero=1 -> o_pc_write_cond=0. Both retire; count +1 each.
- Opcode 111111 at DECODE -> TRAP, o_illegal=1, no writes; held until i_trap_clr=1, then FETCH; o_retired unchanged.
- TIMEOUT=4, ready held 0 in FETCH -> TRAP after 4 wait cycles with ir_write never asserted. Repeat with ready=1 on the 4th cycle -> normal DECODE.
- i_rst asserted during MEM_WR with ready=1 -> no mem_write that cycle; next state FETCH; o_retired=0.

Source files
------------

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle MIPS control FSM and its datapath.
//   master : control unit side (drives the mux selects/enables, reads status)
//   slave  : datapath side (drives opcode/flags/ready, reads the controls)
// Signals:
//   i_opcode, i_zero, i_mem_ready, i_trap_clr      -> into the control unit
//   o_pc_write .. o_pc_src                         -> datapath controls
//   o_illegal, o_instr_done, o_retired, o_state    -> status/debug
interface mips_multicycle_control_if #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 3,
    parameter int CNT_W    = 32
);
    logic [OPCODE_W-1:0] i_opcode;
    logic                i_zero;
    logic                i_mem_ready;
    logic                i_trap_clr;

    logic                o_pc_write;
    logic                o_pc_write_cond;
    logic                o_iord;
    logic                o_mem_read;
    logic                o_mem_write;
    logic                o_ir_write;
    logic                o_reg_dst;
    logic                o_memto_reg;
    logic                o_reg_write;
    logic                o_alu_src_a;
    logic [1:0]          o_alu_src_b;
    logic [ALUOP_W-1:0]  o_alu_op;
    logic [1:0]          o_pc_src;
    logic                o_illegal;
    logic                o_instr_done;
    logic [CNT_W-1:0]    o_retired;
    logic [3:0]          o_state;

    modport master (
        input  i_opcode, i_zero, i_mem_ready, i_trap_clr,
        output o_pc_write, o_pc_write_cond, o_iord, o_mem_read, o_mem_write,
               o_ir_write, o_reg_dst, o_memto_reg, o_reg_write, o_alu_src_a,
               o_alu_src_b, o_alu_op, o_pc_src, o_illegal, o_instr_done,
               o_retired, o_state
    );

    modport slave (
        output i_opcode, i_zero, i_mem_ready, i_trap_clr,
        input  o_pc_write, o_pc_write_cond, o_iord, o_mem_read, o_mem_write,
               o_ir_write, o_reg_dst, o_memto_reg, o_reg_write, o_alu_src_a,
               o_alu_src_b, o_alu_op, o_pc_src, o_illegal, o_instr_done,
               o_retired, o_state
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: sequences each instruction through one shared
// memory port and one ALU, waits on a memory-ready handshake with a bounded
// timeout, traps on illegal opcodes/timeouts and counts retired instructions.
// Ports:
//   i_clk  - clock, rising edge
//   i_rst  - synchronous active-high reset; forces all outputs low meanwhile
//   bus    - control bundle (master side), see mips_multicycle_control_if
module mips_multicycle_control #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 3,
    parameter int TIMEOUT  = 15,
    parameter int CNT_W    = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    mips_multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b000101);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_SLTI  = OPCODE_W'(6'b001010);
    localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(6'b001100);
    localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(6'b001101);
    localparam logic [OPCODE_W-1:0] OP_XORI  = OPCODE_W'(6'b001110);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);

    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALU_FUNC = ALUOP_W'(3'b010);
    localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(3'b011);
    localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(3'b100);
    localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(3'b101);
    localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(3'b110);

    // Last count value before the timeout fires: a cycle that starts here with
    // ready still low is the TIMEOUT-th wait cycle.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [7:0]          wait_q, wait_d;
    logic [CNT_W-1:0]    retired_q;
    logic [OPCODE_W-1:0] opc_q;
    logic                retire;
    logic                in_wait;
    logic                timeout;

    assign in_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // Ready wins over the timeout when both land in the same cycle.
    assign timeout = in_wait && !bus.i_mem_ready && (wait_q == WAIT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            retired_q <= '0;
            opc_q     <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (retire)
                retired_q <= retired_q + 1'b1;
            if (state_q == S_DECODE)
                opc_q <= bus.i_opcode;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        wait_d  = (in_wait && !bus.i_mem_ready && !timeout) ? wait_q + 8'd1 : 8'd0;
        case (state_q)
            S_FETCH: begin
                if (bus.i_mem_ready)  state_d = S_DECODE;
                else if (timeout)     state_d = S_TRAP;
            end
            S_DECODE: begin
                case (bus.i_opcode)
                    OP_RTYPE:                                  state_d = S_R_EXEC;
                    OP_LW, OP_SW:                              state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                            state_d = S_BRANCH;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_I_EXEC;
                    OP_J:                                      state_d = S_JUMP;
                    default:                                   state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: state_d = (opc_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (bus.i_mem_ready)  state_d = S_MEM_WB;
                else if (timeout)     state_d = S_TRAP;
            end
            S_MEM_WR: begin
                if (bus.i_mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_R_EXEC: state_d = S_R_WB;
            S_I_EXEC: state_d = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP: if (bus.i_trap_clr) state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    // Moore output decode; ready-gated strobes and the branch condition are
    // the only input-dependent terms. Reset masks everything.
    always_comb begin
        bus.o_pc_write      = 1'b0;
        bus.o_pc_write_cond = 1'b0;
        bus.o_iord          = 1'b0;
        bus.o_mem_read      = 1'b0;
        bus.o_mem_write     = 1'b0;
        bus.o_ir_write      = 1'b0;
        bus.o_reg_dst       = 1'b0;
        bus.o_memto_reg     = 1'b0;
        bus.o_reg_write     = 1'b0;
        bus.o_alu_src_a     = 1'b0;
        bus.o_alu_src_b     = 2'b00;
        bus.o_alu_op        = ALU_ADD;
        bus.o_pc_src        = 2'b00;
        bus.o_illegal       = 1'b0;
        bus.o_instr_done    = 1'b0;
        if (!i_rst) begin
            bus.o_instr_done = retire;
            case (state_q)
                S_FETCH: begin
                    bus.o_mem_read  = 1'b1;
                    bus.o_alu_src_b = 2'b01;
                    bus.o_ir_write  = bus.i_mem_ready;
                    bus.o_pc_write  = bus.i_mem_ready;
                end
                S_DECODE: bus.o_alu_src_b = 2'b11;
                S_MEM_ADDR: begin
                    bus.o_alu_src_a = 1'b1;
                    bus.o_alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    bus.o_mem_read = 1'b1;
                    bus.o_iord     = 1'b1;
                end
                S_MEM_WB: begin
                    bus.o_reg_write = 1'b1;
                    bus.o_memto_reg = 1'b1;
                end
                S_MEM_WR: begin
                    bus.o_mem_write = 1'b1;
                    bus.o_iord      = 1'b1;
                end
                S_R_EXEC: begin
                    bus.o_alu_src_a = 1'b1;
                    bus.o_alu_op    = ALU_FUNC;
                end
                S_R_WB: begin
                    bus.o_reg_write = 1'b1;
                    bus.o_reg_dst   = 1'b1;
                end
                S_I_EXEC: begin
                    bus.o_alu_src_a = 1'b1;
                    bus.o_alu_src_b = 2'b10;
                    case (opc_q)
                        OP_SLTI: bus.o_alu_op = ALU_SLT;
                        OP_ANDI: bus.o_alu_op = ALU_AND;
                        OP_ORI:  bus.o_alu_op = ALU_OR;
                        OP_XORI: bus.o_alu_op = ALU_XOR;
                        default: bus.o_alu_op = ALU_ADD;
                    endcase
                end
                S_I_WB: bus.o_reg_write = 1'b1;
                S_BRANCH: begin
                    bus.o_alu_src_a     = 1'b1;
                    bus.o_alu_op        = ALU_SUB;
                    bus.o_pc_src        = 2'b01;
                    bus.o_pc_write_cond = ((opc_q == OP_BEQ) &&  bus.i_zero) ||
                                          ((opc_q == OP_BNE) && !bus.i_zero);
                end
                S_JUMP: begin
                    bus.o_pc_src   = 2'b10;
                    bus.o_pc_write = 1'b1;
                end
                S_TRAP: bus.o_illegal = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.o_retired = i_rst ? '0 : retired_q;
    assign bus.o_state   = i_rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
module tb_mips_multicycle_control;
    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_multicycle_control_if bus ();

    mips_multicycle_control #(.TIMEOUT(TIMEOUT)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
        logic        reg_dst, memto_reg, reg_write, alu_src_a;
        logic [1:0]  alu_src_b;
        logic [2:0]  alu_op;
        logic [1:0]  pc_src;
        logic        illegal, instr_done;
        logic [3:0]  state;
        logic [31:0] retired;
    } outs_t;

    function automatic outs_t dut_outs();
        outs_t o;
        o = {bus.o_pc_write, bus.o_pc_write_cond, bus.o_iord, bus.o_mem_read,
             bus.o_mem_write, bus.o_ir_write, bus.o_reg_dst, bus.o_memto_reg,
             bus.o_reg_write, bus.o_alu_src_a, bus.o_alu_src_b, bus.o_alu_op,
             bus.o_pc_src, bus.o_illegal, bus.o_instr_done, bus.o_state, bus.o_retired};
        return o;
    endfunction

    // ---------------- reference model ----------------
    // Instruction-level view: DECODE loads the list of states the instruction
    // still has to walk through; wait states stall on ready with a timeout.
    int          m_state = 0;
    int          m_wait  = 0;
    logic [31:0] m_retired = '0;
    logic [5:0]  m_opc = '0;
    int          m_plan[$];

    function automatic int plan_pop();
        if (m_plan.size() == 0) return 0;
        return m_plan.pop_front();
    endfunction

    function automatic outs_t model_out(logic r, logic z, logic rdy);
        outs_t o = '0;
        if (r) return o;
        o.state   = 4'(m_state);
        o.retired = m_retired;
        case (m_state)
            0:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
            1:  o.alu_src_b = 2'b11;
            2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            3:  begin o.mem_read = 1; o.iord = 1; end
            4:  begin o.reg_write = 1; o.memto_reg = 1; o.instr_done = 1; end
            5:  begin o.mem_write = 1; o.iord = 1; o.instr_done = rdy; end
            6:  begin o.alu_src_a = 1; o.alu_op = 3'b010; end
            7:  begin o.reg_write = 1; o.reg_dst = 1; o.instr_done = 1; end
            8:  begin
                    o.alu_src_a = 1; o.alu_src_b = 2'b10;
                    case (m_opc)
                        6'd10:   o.alu_op = 3'b011;
                        6'd12:   o.alu_op = 3'b100;
                        6'd13:   o.alu_op = 3'b101;
                        6'd14:   o.alu_op = 3'b110;
                        default: o.alu_op = 3'b000;
                    endcase
                end
            9:  begin o.reg_write = 1; o.instr_done = 1; end
            10: begin
                    o.alu_src_a = 1; o.alu_op = 3'b001; o.pc_src = 2'b01; o.instr_done = 1;
                    o.pc_write_cond = (m_opc == 6'd4) ? z : (m_opc == 6'd5) ? !z : 1'b0;
                end
            11: begin o.pc_src = 2'b10; o.pc_write = 1; o.instr_done = 1; end
            12: o.illegal = 1;
            default: ;
        endcase
        return o;
    endfunction

    function automatic void model_step(logic r, logic [5:0] opc, logic rdy, logic clr);
        if (r) begin
            m_state = 0; m_wait = 0; m_retired = '0; m_plan.delete();
            return;
        end
        case (m_state)
            0, 3, 5: begin
                if (rdy) begin
                    m_wait = 0;
                    if (m_state == 5) m_retired = m_retired + 1;
                    m_state = (m_state == 0) ? 1 : plan_pop();
                end else begin
                    m_wait++;
                    if (m_wait == TIMEOUT) begin
                        m_wait = 0; m_plan.delete(); m_state = 12;
                    end
                end
            end
            1: begin
                m_opc = opc;
                m_plan.delete();
                case (opc)
                    6'd0:                        m_plan = '{6, 7};
                    6'd35:                       m_plan = '{2, 3, 4};
                    6'd43:                       m_plan = '{2, 5};
                    6'd4, 6'd5:                  m_plan = '{10};
                    6'd8, 6'd10, 6'd12, 6'd13, 6'd14: m_plan = '{8, 9};
                    6'd2:                        m_plan = '{11};
                    default:                     m_plan.delete();
                endcase
                m_state = (m_plan.size() == 0) ? 12 : plan_pop();
            end
            12: if (clr) m_state = 0;
            default: begin
                if (m_state inside {4, 7, 9, 10, 11}) m_retired = m_retired + 1;
                m_state = plan_pop();
            end
        endcase
    endfunction

    // ---------------- directed table ----------------
    typedef struct packed {
        logic       rst;
        logic [5:0] opc;
        logic       zero, rdy, clr;
        logic [3:0] st;
        logic [4:0] wr;   // {pc_write, pc_write_cond, mem_write, ir_write, reg_write}
        logic       done, ill;
        logic [7:0] ret;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic r, input logic [5:0] opc, input logic z, input logic rdy,
                       input logic clr, input logic [3:0] st, input logic [4:0] wr,
                       input logic done, input logic ill, input logic [7:0] ret);
        vec_t v;
        v = '{r, opc, z, rdy, clr, st, wr, done, ill, ret};
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [5:0] opc, input logic z,
                         input logic rdy, input logic clr);
        rst = r;
        bus.i_opcode = opc;
        bus.i_zero = z;
        bus.i_mem_ready = rdy;
        bus.i_trap_clr = clr;
    endtask

    task automatic rstep(input logic r, input logic [5:0] opc, input logic z,
                         input logic rdy, input logic clr, input int cyc);
        outs_t got, exp;
        drive(r, opc, z, rdy, clr);
        @(negedge clk);
        exp = model_out(r, z, rdy);
        got = dut_outs();
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL rand cyc %0d: got %h want %h (state got %0d want %0d)",
                     cyc, got, exp, got.state, exp.state);
        end
        @(posedge clk);
        model_step(r, opc, rdy, clr);
        #1;
    endtask

    initial begin
        int pool[12];
        logic [5:0] opc;
        int thresh;
        outs_t g;
        logic [4:0] gwr;
        pool = '{0, 35, 43, 4, 5, 8, 10, 12, 13, 14, 2, 0};

        //    rst opc       z  rdy clr st  wr        dn il ret
        add(1, 6'd0,  0, 1, 0, 0,  5'b00000, 0, 0, 0);   // reset
        add(0, 6'd0,  0, 1, 0, 0,  5'b10010, 0, 0, 0);   // ADD fetch
        add(0, 6'd0,  0, 1, 0, 1,  5'b00000, 0, 0, 0);
        add(0, 6'd0,  0, 1, 0, 6,  5'b00000, 0, 0, 0);
        add(0, 6'd0,  0, 1, 0, 7,  5'b00001, 1, 0, 0);
        add(0, 6'd0,  0, 1, 0, 0,  5'b10010, 0, 0, 1);   // LW fetch, retired=1
        add(0, 6'd35, 0, 1, 0, 1,  5'b00000, 0, 0, 1);
        add(0, 6'd0,  0, 1, 0, 2,  5'b00000, 0, 0, 1);   // opcode change ignored
        add(0, 6'd0,  0, 0, 0, 3,  5'b00000, 0, 0, 1);
        add(0, 6'd0,  0, 0, 0, 3,  5'b00000, 0, 0, 1);
        add(0, 6'd0,  0, 0, 0, 3,  5'b00000, 0, 0, 1);
        add(0, 6'd0,  0, 1, 0, 3,  5'b00000, 0, 0, 1);   // ready at last wait cycle wins
        add(0, 6'd0,  0, 1, 0, 4,  5'b00001, 1, 0, 1);
        add(0, 6'd0,  0, 1, 0, 0,  5'b10010, 0, 0, 2);   // BEQ
        add(0, 6'd4,  1, 1, 0, 1,  5'b00000, 0, 0, 2);
        add(0, 6'd0,  1, 1, 0, 10, 5'b01000, 1, 0, 2);
        add(0, 6'd0,  1, 1, 0, 0,  5'b10010, 0, 0, 3);   // BNE
        add(0, 6'd5,  1, 1, 0, 1,  5'b00000, 0, 0, 3);
        add(0, 6'd0,  1, 1, 0, 10, 5'b00000, 1, 0, 3);
        add(0, 6'd0,  0, 1, 0, 0,  5'b10010, 0, 0, 4);   // illegal
        add(0, 6'd63, 0, 1, 0, 1,  5'b00000, 0, 0, 4);
        add(0, 6'd0,  0, 1, 0, 12, 5'b00000, 0, 1, 4);
        add(0, 6'd0,  0, 1, 0, 12, 5'b00000, 0, 1, 4);
        add(0, 6'd0,  0, 1, 1, 12, 5'b00000, 0, 1, 4);
        add(0, 6'd0,  0, 0, 0, 0,  5'b00000, 0, 0, 4);   // fetch timeout
        add(0, 6'd0,  0, 0, 0, 0,  5'b00000, 0, 0, 4);
        add(0, 6'd0,  0, 0, 0, 0,  5'b00000, 0, 0, 4);
        add(0, 6'd0,  0, 0, 0, 0,  5'b00000, 0, 0, 4);
        add(0, 6'd0,  0, 0, 1, 12, 5'b00000, 0, 1, 4);
        add(0, 6'd0,  0, 0, 0, 0,  5'b00000, 0, 0, 4);   // ready on 4th cycle
        add(0, 6'd0,  0, 0, 0, 0,  5'b00000, 0, 0, 4);
        add(0, 6'd0,  0, 0, 0, 0,  5'b00000, 0, 0, 4);
        add(0, 6'd0,  0, 1, 0, 0,  5'b10010, 0, 0, 4);
        add(0, 6'd43, 0, 1, 0, 1,  5'b00000, 0, 0, 4);   // SW
        add(0, 6'd0,  0, 1, 0, 2,  5'b00000, 0, 0, 4);
        add(0, 6'd0,  0, 0, 0, 5,  5'b00100, 0, 0, 4);
        add(1, 6'd0,  0, 1, 0, 0,  5'b00000, 0, 0, 0);   // reset mid-write
        add(0, 6'd0,  0, 0, 0, 0,  5'b00000, 0, 0, 0);

        drive(1, 6'd0, 0, 1, 0);
        @(posedge clk); #1;
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].opc, tbl[i].zero, tbl[i].rdy, tbl[i].clr);
            @(negedge clk);
            g = dut_outs();
            gwr = {g.pc_write, g.pc_write_cond, g.mem_write, g.ir_write, g.reg_write};
            checks++;
            if (g.state !== tbl[i].st || gwr !== tbl[i].wr || g.instr_done !== tbl[i].done ||
                g.illegal !== tbl[i].ill || g.retired !== 32'(tbl[i].ret)) begin
                fails++;
                $display("FAIL vec %0d: got st=%0d wr=%b done=%b ill=%b ret=%0d want st=%0d wr=%b done=%b ill=%b ret=%0d",
                         i, g.state, gwr, g.instr_done, g.illegal, g.retired,
                         tbl[i].st, tbl[i].wr, tbl[i].done, tbl[i].ill, tbl[i].ret);
            end
            @(posedge clk); #1;
        end

        // Randomised run against the model, starting from a clean reset.
        rstep(1, 6'd0, 0, 0, 0, -1);
        thresh = 7;
        for (int c = 0; c < 1500; c++) begin
            int k;
            if (c % 150 == 0) thresh = $urandom_range(2, 9);
            k = $urandom_range(0, 11);
            opc = (k == 11) ? 6'($urandom) : 6'(pool[k]);
            rstep(($urandom_range(0, 99) == 0), opc, 1'($urandom),
                  ($urandom_range(0, 9) < thresh), ($urandom_range(0, 3) == 0), c);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
